// File: rtl/window_serializer.sv
// window_serializer: takes one 3x3 pixel window per valid/ready handshake.
// It emits the nine pixels column-major on a byte stream. The receiver's shift
// enable `en` leads the data by EN_LEAD cycles, which matches the receiver's
// internal enable delay.
module window_serializer #(
  parameter int DW      = 8,
  parameter int EN_LEAD = 3   // legal range 0..7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          win_valid,
  output logic          win_ready,
  input  logic [DW-1:0] win00,
  input  logic [DW-1:0] win01,
  input  logic [DW-1:0] win02,
  input  logic [DW-1:0] win10,
  input  logic [DW-1:0] win11,
  input  logic [DW-1:0] win12,
  input  logic [DW-1:0] win20,
  input  logic [DW-1:0] win21,
  input  logic [DW-1:0] win22,
  output logic          en,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          frame_done
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'd8;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;

  // Holding buffer, stored already in emission order (column-major).
  logic [DW-1:0] pix_q [9];
  logic [DW-1:0] pix_d [9];

  logic          accept;
  logic          en_d;
  logic          last_d;
  logic [DW-1:0] sel_d;

  // Stage 0 is loaded from the next-state view so that `en` (stage 0) is
  // registered. Stage EN_LEAD drives the data outputs.
  logic [DW-1:0] dly_data_q [EN_LEAD+1];
  logic [EN_LEAD:0] dly_en_q;
  logic [EN_LEAD:0] dly_last_q;

  // Ready depends only on state and count, never on win_valid.
  assign win_ready = (state_q == IDLE) || (cnt_q == LAST_CNT);
  assign accept    = win_valid && win_ready;

  // Capture the window into the buffer in serialization order on accept.
  always_comb begin
    // NOTE: default every combinational output first so that no path leaves it unassigned, which would infer a latch.
    pix_d = pix_q;
    if (accept) begin
      pix_d[0] = win00;
      pix_d[1] = win10;
      pix_d[2] = win20;
      pix_d[3] = win01;
      pix_d[4] = win11;
      pix_d[5] = win21;
      pix_d[6] = win02;
      pix_d[7] = win12;
      pix_d[8] = win22;
    end
  end

  // IDLE/SEND sequencing with a 0..8 byte counter; a frame can chain back-to-back.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
        if (accept) state_d = SEND;
      end
      SEND: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = 4'd0;
          if (!accept) state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Select the byte to launch next cycle. Zeros are launched while not sending.
  always_comb begin
    en_d   = (state_d == SEND);
    last_d = en_d && (cnt_d == LAST_CNT);
    sel_d  = '0;
    if (en_d) sel_d = pix_d[cnt_d];
  end

  // FSM state, byte counter and holding buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the buffer is reset because it is only 9 bytes, and a known value keeps dout deterministic after reset.
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      for (int i = 0; i < 9; i++) pix_q[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < 9; i++) pix_q[i] <= pix_d[i];
    end
  end

  // Delay line that holds the data EN_LEAD cycles behind `en`. Reset clears it immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= EN_LEAD; i++) dly_data_q[i] <= '0;
      dly_en_q   <= '0;
      dly_last_q <= '0;
    end else begin
      dly_data_q[0] <= sel_d;
      dly_en_q[0]   <= en_d;
      dly_last_q[0] <= last_d;
      for (int i = 1; i <= EN_LEAD; i++) begin
        dly_data_q[i] <= dly_data_q[i-1];
        dly_en_q[i]   <= dly_en_q[i-1];
        dly_last_q[i] <= dly_last_q[i-1];
      end
    end
  end

  assign en         = dly_en_q[0];
  assign dout       = dly_data_q[EN_LEAD];
  assign dout_valid = dly_en_q[EN_LEAD];
  assign frame_done = dly_last_q[EN_LEAD];

endmodule

// File: tb/tb_window_serializer.sv
// Testbench for window_serializer. Two instances share the same stimulus,
// one with EN_LEAD=3 and one with EN_LEAD=0. A cycle-indexed schedule model
// predicts en/dout/dout_valid/frame_done/win_ready. Received frames are
// reassembled into windows and compared with the accepted windows.
module tb_window_serializer;

  localparam int DW = 8;
  localparam int N  = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic win_valid = 1'b0;
  logic [DW-1:0] w [9];   // row-major: index r*3+c

  logic ready3, en3, dv3, fd3;
  logic ready0, en0, dv0, fd0;
  logic [DW-1:0] dout3, dout0;

  always #5 clk = ~clk;

  window_serializer #(.DW(DW), .EN_LEAD(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .win_valid(win_valid), .win_ready(ready3),
    .win00(w[0]), .win01(w[1]), .win02(w[2]),
    .win10(w[3]), .win11(w[4]), .win12(w[5]),
    .win20(w[6]), .win21(w[7]), .win22(w[8]),
    .en(en3), .dout(dout3), .dout_valid(dv3), .frame_done(fd3)
  );

  window_serializer #(.DW(DW), .EN_LEAD(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .win_valid(win_valid), .win_ready(ready0),
    .win00(w[0]), .win01(w[1]), .win02(w[2]),
    .win10(w[3]), .win11(w[4]), .win12(w[5]),
    .win20(w[6]), .win21(w[7]), .win22(w[8]),
    .en(en0), .dout(dout0), .dout_valid(dv0), .frame_done(fd0)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- model ----------------
  // Cycle c is the clock period that follows rising edge c-1.
  // An accept at edge A launches byte k of the window in cycle A+1+k.
  int   cyc = 0;
  int   last_rst = 0;
  int   last_acc = -1;
  int   acc_count = 0;
  bit   sch_en   [N];
  bit   sch_last [N];
  int   sch_k    [N];
  logic [7:0] sch_byte [N];
  logic [71:0] q3[$];
  logic [71:0] q0[$];

  function automatic logic [71:0] pack_win();
    logic [71:0] p;
    for (int i = 0; i < 9; i++) p[8*i +: 8] = w[i];
    return p;
  endfunction

  task automatic set_win(input logic [71:0] p);
    for (int i = 0; i < 9; i++) w[i] = p[8*i +: 8];
  endtask

  function automatic bit model_ready(input int c);
    return !(sch_en[c] && sch_k[c] < 8);
  endfunction

  task automatic exp_out(input int lead, input int c, output bit v, output logic [7:0] b, output bit l);
    int s;
    s = c - lead;
    v = 1'b0; b = 8'h00; l = 1'b0;
    if (s >= 0 && !(s < last_rst && c >= last_rst)) begin
      v = sch_en[s];
      l = sch_last[s];
      if (v) b = sch_byte[s];
    end
  endtask

  always @(posedge clk) begin
    if (rst_n && win_valid && model_ready(cyc)) begin
      for (int k = 0; k < 9; k++) begin
        sch_en[cyc+1+k]   = 1'b1;
        sch_k[cyc+1+k]    = k;
        sch_last[cyc+1+k] = (k == 8);
        sch_byte[cyc+1+k] = w[(k % 3) * 3 + (k / 3)];
      end
      last_acc = cyc;
      acc_count++;
      q3.push_back(pack_win());
      q0.push_back(pack_win());
    end
    cyc++;
  end

  logic [7:0] coll [2][9];
  int ncoll [2];

  always @(negedge rst_n) begin
    for (int i = cyc; i < N; i++) begin
      sch_en[i] = 1'b0; sch_last[i] = 1'b0; sch_k[i] = 0; sch_byte[i] = 8'h00;
    end
    last_rst = cyc;
    q3.delete();
    q0.delete();
    ncoll[0] = 0;
    ncoll[1] = 0;
  end

  // Receiver view: byte k lands at row k%3, column k/3.
  task automatic collect(input int d, input logic dv, input logic [7:0] b, input logic fd);
    logic [71:0] got, expw;
    int sz;
    if (dv) begin
      if (ncoll[d] < 9) coll[d][ncoll[d]] = b;
      ncoll[d]++;
    end
    if (fd) begin
      check($sformatf("frame_len%0d", d), ncoll[d], 9);
      sz = (d == 0) ? q3.size() : q0.size();
      check($sformatf("frame_pending%0d", d), sz > 0, 1'b1);
      if (sz > 0) begin
        if (d == 0) expw = q3.pop_front();
        else        expw = q0.pop_front();
        got = '0;
        for (int k = 0; k < 9; k++) got[8*((k % 3) * 3 + (k / 3)) +: 8] = coll[d][k];
        check($sformatf("frame_window%0d", d), got, expw);
      end
      ncoll[d] = 0;
    end
  endtask

  int run3 = 0, last_run = 0, fd_total = 0;

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    bit v; bit l; logic [7:0] b;
    check("win_ready3", ready3, model_ready(cyc));
    check("win_ready0", ready0, model_ready(cyc));
    check("en3", en3, sch_en[cyc]);
    check("en0", en0, sch_en[cyc]);
    exp_out(3, cyc, v, b, l);
    check("dout_valid3", dv3, v);
    check("dout3", dout3, b);
    check("frame_done3", fd3, l);
    exp_out(0, cyc, v, b, l);
    check("dout_valid0", dv0, v);
    check("dout0", dout0, b);
    check("frame_done0", fd0, l);
    if (rst_n) begin
      collect(0, dv3, dout3, fd3);
      collect(1, dv0, dout0, fd0);
    end
    if (en3) run3++;
    else if (run3 > 0) begin
      last_run = run3;
      run3 = 0;
    end
    if (fd3) fd_total++;
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_cyc(input int c);
    int guard = 0;
    while (cyc < c && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("wait_cyc_timeout", cyc >= c, 1'b1);
  endtask

  task automatic wait_accept();
    int n0, guard;
    n0 = acc_count;
    guard = 0;
    while (acc_count == n0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("accept_timeout", acc_count, n0 + 1);
  endtask

  function automatic logic [71:0] bp_pat(input int i);
    logic [71:0] p;
    for (int j = 0; j < 9; j++) p[8*j +: 8] = 8'(16 * i + j);
    return p;
  endfunction

  logic [7:0] lit [9];
  int a, fd0_start, i;

  initial begin
    lit = '{8'h11, 8'h21, 8'h31, 8'h12, 8'h22, 8'h32, 8'h13, 8'h23, 8'h33};
    set_win('0);
    repeat (3) @(negedge clk);
    // Reset values
    check("rst_ready", ready3, 1'b1);
    check("rst_en", en3, 1'b0);
    check("rst_dout", dout3, 8'h00);
    check("rst_dvalid", dv3, 1'b0);
    check("rst_fdone", fd3, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single window with the literal pattern (row-major 11..33)
    set_win(72'h33_32_31_23_22_21_13_12_11);
    win_valid = 1'b1;
    wait_accept();
    win_valid = 1'b0;
    a = last_acc;
    for (int c = a + 1; c <= a + 13; c++) begin
      wait_cyc(c);
      check("lit_en", en3, (c <= a + 9));
      if (c >= a + 4 && c <= a + 12) check("lit_dout3", dout3, lit[c-a-4]);
      if (c <= a + 9) check("lit_dout0", dout0, lit[c-a-1]);
      check("lit_fdone3", fd3, (c == a + 12));
    end
    check("lit_en_run", last_run, 9);
    repeat (4) @(negedge clk);

    // Back-to-back: three windows with win_valid held high
    fd0_start = fd_total;
    set_win(72'h09_08_07_06_05_04_03_02_01);
    win_valid = 1'b1;
    wait_accept();
    set_win(72'hA9_A8_A7_A6_A5_A4_A3_A2_A1);
    wait_accept();
    set_win(72'hF0_E1_D2_C3_B4_A5_96_87_78);
    wait_accept();
    win_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("b2b_en_run", last_run, 27);
    check("b2b_frames", fd_total - fd0_start, 3);

    // Backpressure: request at cnt=3 with changing data, accepted only at cnt=8
    set_win(72'h5A_4B_3C_2D_1E_0F_C0_B0_A0);
    win_valid = 1'b1;
    wait_accept();
    win_valid = 1'b0;
    a = last_acc;
    wait_cyc(a + 4);
    i = 0;
    fd0_start = acc_count;
    while (acc_count == fd0_start && i < 20) begin
      set_win(bp_pat(i));
      win_valid = 1'b1;
      check("bp_ready", ready3, (cyc == a + 9));
      @(negedge clk);
      i++;
    end
    win_valid = 1'b0;
    check("bp_accept_edge", last_acc, a + 9);
    wait_cyc(a + 13);
    check("bp_byte0", dout3, 8'h50);
    wait_cyc(a + 14);
    check("bp_byte1", dout3, 8'h53);
    repeat (16) @(negedge clk);

    // Reset mid-frame at cnt=5
    set_win(72'h99_88_77_66_55_44_33_22_11);
    win_valid = 1'b1;
    wait_accept();
    win_valid = 1'b0;
    a = last_acc;
    wait_cyc(a + 6);
    check("pre_rst_dvalid3", dv3, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_en", en3, 1'b0);
    check("mid_rst_dout", dout3, 8'h00);
    check("mid_rst_dvalid", dv3, 1'b0);
    check("mid_rst_ready", ready3, 1'b1);
    check("mid_rst_dout0", dout0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Next window after reset starts from byte 0
    set_win(72'hC9_C8_C7_C6_C5_C4_C3_C2_C1);
    win_valid = 1'b1;
    wait_accept();
    win_valid = 1'b0;
    a = last_acc;
    check("post_rst_byte0_l0", dout0, 8'hC1);
    wait_cyc(a + 4);
    check("post_rst_byte0_l3", dout3, 8'hC1);
    wait_cyc(a + 5);
    check("post_rst_byte1_l3", dout3, 8'hC4);
    repeat (20) @(negedge clk);
    check("drain3", q3.size(), 0);
    check("drain0", q0.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
